smpl_core_mc: RTL
=================

// Module: smpl_core_mc
// PURPOSE
//  Parametrised multi-cycle successor of the smpl accumulator core. Fetches one
//  instruction per pass, executes ADD/SUB/AND/OR/LDA/STA/JMP/JZ, and talks to
//  data memory through a ready handshake with wait states and timeout.
//  Sits between instruction ROM (iaddr/idata) and data RAM (daddr/datai/datao).
// PARAMETERS
//  DW      16  data/instruction width; DW >= AW+3
//  AW      13  instruction and data address width
//  TIMEOUT 15  max wait cycles for dready before bus error; 0 = wait forever
// PORTS
//  clock    in   1   single clock, all state on rising edge
//  reset    in   1   synchronous, active-high
//  iaddr    out  AW  instruction address (= pc)
//  idata    in   DW  instruction word; opcode idata[DW-1:DW-3], operand idata[AW-1:0]
//  daddr    out  AW  data address
//  datai    in   DW  read data, valid when dready=1
//  datao    out  DW  write data (= acc during STA)
//  renbl    out  1   read request, held until dready or timeout
//  wenbl    out  1   write request, held until dready or timeout
//  dready   in   1   memory completes current request this cycle
//  acc_o    out  DW  accumulator (debug)
//  zflag    out  1   acc == 0 after last acc write
//  cflag    out  1   carry (ADD) / borrow (SUB)
//  bus_err  out  1   sticky: a data access timed out
// BEHAVIOUR
//  - All outputs registered except iaddr (= pc). Reset: pc=0, acc=0, zflag=0,
//    cflag=0, bus_err=0, renbl=wenbl=0, daddr=0, datao=0, state=FETCH.
//  - Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LDA, 101 STA, 110 JMP, 111 JZ.
//  - FSM FETCH -> EXEC -> {MEM -> FETCH | FETCH}.
//    FETCH: ir <= idata. EXEC: JMP pc<=operand; JZ pc<=zflag?operand:pc+1;
//    both return to FETCH (2 cycles). Others: daddr<=operand, renbl<=1 (ALU/LDA)
//    or wenbl<=1, datao<=acc (STA), go MEM. MEM: on dready, drop req, apply op,
//    pc<=pc+1, go FETCH. Zero-wait memory instruction = 3 cycles.
//  - Wait counter clears on MEM entry, increments each MEM cycle without dready;
//    if TIMEOUT!=0 and count reaches TIMEOUT: drop req, bus_err<=1, acc/flags
//    unchanged, pc<=pc+1, go FETCH. dready on the timeout cycle wins (no error).
//  - ADD: {cflag,acc} <= acc+datai. SUB: acc <= acc-datai, cflag <= (acc<datai).
//    AND/OR/LDA: cflag unchanged. zflag <= (new acc==0) on every acc write;
//    STA/JMP/JZ leave flags unchanged.
//  - pc wraps 2^AW-1 -> 0. dready outside MEM is ignored.
//  - Reset mid-MEM: request dropped at the reset edge, no acc/flag/pc update.
// STRUCTURE
//  - Package smpl_pkg: opcode_e (3-bit enum above), state_e {FETCH,EXEC,MEM}.
//  - Sub-module smpl_alu: combinational; op, acc, datai -> result, carry.
//  - Core holds FSM, pc, ir, acc, flags, wait counter, bus registers.
// TESTING
//  1. reset, prog LDA 5; ADD 6 with mem[5]=0x7FFF, mem[6]=0x0001, dready=1
//     -> acc=0x8000, cflag=0, zflag=0; each instruction takes 3 cycles.
//  2. ADD with acc=0xFFFF, datai=0x0001 -> acc=0x0000, cflag=1, zflag=1.
//  3. SUB with acc=0x0003, datai=0x0005 -> acc=0xFFFE, cflag=1; then AND
//     datai=0x00F0 -> acc=0x00F0, cflag still 1.
//  4. STA 0x0010 with dready delayed 4 cycles -> wenbl high 5 cycles,
//     daddr=0x0010, datao=acc; pc advances only after dready.
//  5. JZ 0x0100 with zflag=1 -> iaddr=0x0100 after 2 cycles; zflag=0 -> pc+1;
//     pc=0x1FFF non-jump -> wraps to 0x0000.
//  6. TIMEOUT=15, dready held low -> renbl drops after 15 MEM cycles, bus_err=1,
//     acc unchanged, next fetch proceeds; reset asserted mid-wait clears all.

Source files
------------

// File: rtl/smpl_core_mc_pkg.sv
// Shared types for the multi-cycle smpl accumulator core: opcode encoding,
// FSM states and a small opcode classification helper.
package smpl_core_mc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_LDA = 3'b100,
        OP_STA = 3'b101,
        OP_JMP = 3'b110,
        OP_JZ  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        MEM
    } state_e;

    // Only the arithmetic ops produce a carry/borrow; logic ops and loads keep it.
    function automatic logic writesCarry(opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/smpl_core_mc_if.sv
// Instruction-fetch and data-memory bus of the smpl core. The core is the
// master; instruction ROM and data RAM sit behind the slave side.
interface smpl_core_mc_if #(
    parameter int DW = 16,
    parameter int AW = 13
);
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic [AW-1:0] daddr;
    logic [DW-1:0] datai;
    logic [DW-1:0] datao;
    logic          renbl;
    logic          wenbl;
    logic          dready;

    modport master (
        output iaddr, daddr, datao, renbl, wenbl,
        input  idata, datai, dready
    );

    modport slave (
        input  iaddr, daddr, datao, renbl, wenbl,
        output idata, datai, dready
    );
endinterface

// File: rtl/smpl_core_mc_alu.sv
// Combinational ALU of the smpl core: combines the accumulator with memory
// read data and reports carry (ADD) or borrow (SUB).
module smpl_core_mc_alu
    import smpl_core_mc_pkg::*;
#(
    parameter int DW = 16
) (
    input  opcode_e         op_i,
    input  logic [DW-1:0]   acc_i,
    input  logic [DW-1:0]   datai_i,
    output logic [DW-1:0]   result_o,
    output logic            carry_o
);

    always_comb begin
        result_o = acc_i;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: {carry_o, result_o} = {1'b0, acc_i} + {1'b0, datai_i};
            OP_SUB: begin
                result_o = acc_i - datai_i;
                carry_o  = (acc_i < datai_i);
            end
            OP_AND: result_o = acc_i & datai_i;
            OP_OR:  result_o = acc_i | datai_i;
            OP_LDA: result_o = datai_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/smpl_core_mc.sv
// Multi-cycle smpl accumulator core: FETCH/EXEC/MEM sequencer with a
// wait-state data bus, optional access timeout and sticky bus error.
module smpl_core_mc
    import smpl_core_mc_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 13,
    parameter int TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            reset,
    smpl_core_mc_if.master  bus,
    output logic [DW-1:0]   acc_o,
    output logic            zflag,
    output logic            cflag,
    output logic            bus_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    opcode_e       opcode_q, opcode_d;
    logic [AW-1:0] operand_q, operand_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          z_q, z_d;
    logic          c_q, c_d;
    logic          err_q, err_d;
    logic          ren_q, ren_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] daddr_q, daddr_d;
    logic [DW-1:0] datao_q, datao_d;
    logic [CW-1:0] wcnt_q, wcnt_d;

    logic [DW-1:0] aluResult;
    logic          aluCarry;
    logic          timeoutHit;

    smpl_core_mc_alu #(.DW(DW)) u_alu (
        .op_i     (opcode_q),
        .acc_i    (acc_q),
        .datai_i  (bus.datai),
        .result_o (aluResult),
        .carry_o  (aluCarry)
    );

    // This MEM cycle is the last allowed one without dready.
    assign timeoutHit = (TIMEOUT != 0) && ((int'(wcnt_q) + 1) == TIMEOUT);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        z_d       = z_q;
        c_d       = c_q;
        err_d     = err_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        daddr_d   = daddr_q;
        datao_d   = datao_q;
        wcnt_d    = wcnt_q;

        case (state_q)
            FETCH: begin
                opcode_d  = opcode_e'(bus.idata[DW-1:DW-3]);
                operand_d = bus.idata[AW-1:0];
                state_d   = EXEC;
            end
            EXEC: begin
                case (opcode_q)
                    OP_JMP: begin
                        pc_d    = operand_q;
                        state_d = FETCH;
                    end
                    OP_JZ: begin
                        pc_d    = z_q ? operand_q : pc_q + 1'b1;
                        state_d = FETCH;
                    end
                    OP_STA: begin
                        daddr_d = operand_q;
                        datao_d = acc_q;
                        wen_d   = 1'b1;
                        wcnt_d  = '0;
                        state_d = MEM;
                    end
                    default: begin
                        daddr_d = operand_q;
                        ren_d   = 1'b1;
                        wcnt_d  = '0;
                        state_d = MEM;
                    end
                endcase
            end
            MEM: begin
                // dready is checked first so a late completion beats the timeout.
                if (bus.dready) begin
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    pc_d    = pc_q + 1'b1;
                    state_d = FETCH;
                    if (opcode_q != OP_STA) begin
                        acc_d = aluResult;
                        z_d   = (aluResult == '0);
                        if (writesCarry(opcode_q)) begin
                            c_d = aluCarry;
                        end
                    end
                end else if (timeoutHit) begin
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    err_d   = 1'b1;
                    pc_d    = pc_q + 1'b1;
                    state_d = FETCH;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= '0;
            opcode_q  <= OP_ADD;
            operand_q <= '0;
            acc_q     <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            err_q     <= 1'b0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            daddr_q   <= '0;
            datao_q   <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            z_q       <= z_d;
            c_q       <= c_d;
            err_q     <= err_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            daddr_q   <= daddr_d;
            datao_q   <= datao_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign bus.iaddr = pc_q;
    assign bus.daddr = daddr_q;
    assign bus.datao = datao_q;
    assign bus.renbl = ren_q;
    assign bus.wenbl = wen_q;
    assign acc_o     = acc_q;
    assign zflag     = z_q;
    assign cflag     = c_q;
    assign bus_err   = err_q;

endmodule
